// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants, framing-state encoding and a seconds-to-cycles helper
// used by the LED-string driver, the transmitter and the receiver.
package ws2812_pkg;

    localparam real T0H     = 0.4e-6;
    localparam real T1H     = 0.8e-6;
    localparam real T_BIT   = 1.25e-6;
    localparam real T_RESET = 50e-6;
    localparam real T_THR   = 0.55e-6;
    localparam real T_HMAX  = 5e-6;

    localparam int WORD_W = 24;

    typedef enum logic [4:0] {
        SYNC    = 5'b00001,
        READY   = 5'b00010,
        HIGH    = 5'b00100,
        LOW     = 5'b01000,
        FORWARD = 5'b10000
    } state_t;

    // ceil(t*f); the small tolerance keeps exact products such as 50us*48MHz from rounding up
    function automatic int cycles(input real t, input real f);
        real x;
        int  n;
        x = t * f;
        n = $rtoi(x);
        if (real'(n) < x - 1.0e-6) begin
            n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/ws2812_rx_phy.sv
// Line front end: 2-FF synchronizer, edge detect, high-time measurement and
// low-run counting; emits bit strobe/value, over-long-high flag and reset-gap strobe.
module ws2812_rx_phy
    import ws2812_pkg::*;
#(
    parameter int N_THR  = cycles(T_THR, 48.0e6),
    parameter int N_RST  = cycles(T_RESET, 48.0e6),
    parameter int N_HMAX = cycles(T_HMAX, 48.0e6),
    parameter int CNT_W  = $clog2(N_RST + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic din_s,
    output logic rise,
    output logic bit_stb,
    output logic bit_val,
    output logic hi_long,
    output logic gap
);

    localparam logic [CNT_W-1:0] THR_C  = CNT_W'(N_THR);
    localparam logic [CNT_W-1:0] RST_C  = CNT_W'(N_RST);
    localparam logic [CNT_W-1:0] HMAX_C = CNT_W'(N_HMAX);

    logic             sync_p0;
    logic             din_p2;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] low_cnt;

    // sync_p0 -> din_s is the synchronizer; din_p2 is the edge-detect reference
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            din_s   <= 1'b0;
            din_p2  <= 1'b0;
            hi_cnt  <= '0;
            low_cnt <= '0;
            gap     <= 1'b0;
        end else begin
            sync_p0 <= din;
            din_s   <= sync_p0;
            din_p2  <= din_s;
            gap     <= 1'b0;
            if (din_s) begin
                low_cnt <= '0;
                if (!din_p2) begin
                    hi_cnt <= CNT_W'(1);
                end else if (hi_cnt != '1) begin
                    hi_cnt <= hi_cnt + CNT_W'(1);
                end
            end else begin
                if (low_cnt != RST_C) begin
                    low_cnt <= low_cnt + CNT_W'(1);
                end
                // low_cnt saturates at N_RST, so this fires once per gap
                if (low_cnt == RST_C - CNT_W'(1)) begin
                    gap <= 1'b1;
                end
            end
        end
    end

    assign rise    = din_s & ~din_p2;
    assign bit_stb = ~din_s & din_p2;
    assign bit_val = (hi_cnt >= THR_C);
    assign hi_long = (hi_cnt >= HMAX_C);

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 pixel emulator: captures the first 24 bits after a reset gap into data,
// then regenerates the rest of the frame on dout for the next pixel in the chain.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter real F_CLK       = 48.0e6,
    parameter real T_THR_S     = T_THR,
    parameter real T_RESET_S   = T_RESET,
    parameter real T_HMAX_S    = T_HMAX
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic              dout,
    output logic [WORD_W-1:0] data,
    output logic              valid,
    output logic              frame,
    output logic              err
);

    localparam int N_THR  = cycles(T_THR_S, F_CLK);
    localparam int N_RST  = cycles(T_RESET_S, F_CLK);
    localparam int N_HMAX = cycles(T_HMAX_S, F_CLK);
    localparam int CNT_W  = $clog2(N_RST + 1);
    localparam logic [4:0] LAST_BIT = 5'(WORD_W - 1);

    logic din_s;
    logic rise;
    logic bit_stb;
    logic bit_val;
    logic hi_long;
    logic gap;

    ws2812_rx_phy #(
        .N_THR  (N_THR),
        .N_RST  (N_RST),
        .N_HMAX (N_HMAX),
        .CNT_W  (CNT_W)
    ) u_phy (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .din_s   (din_s),
        .rise    (rise),
        .bit_stb (bit_stb),
        .bit_val (bit_val),
        .hi_long (hi_long),
        .gap     (gap)
    );

    state_t            state;
    state_t            state_nxt;
    logic [4:0]        bit_cnt;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] word_nxt;
    logic              valid_nxt;
    logic              frame_nxt;
    logic              err_nxt;
    logic              dout_nxt;
    logic              shift;
    logic              clr;

    assign word_nxt = {shreg[WORD_W-2:0], bit_val};

    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        frame_nxt = 1'b0;
        err_nxt   = 1'b0;
        dout_nxt  = 1'b0;
        shift     = 1'b0;
        clr       = 1'b0;
        unique case (state)
            SYNC: begin
                clr = 1'b1;
                if (gap) state_nxt = READY;
            end
            READY: begin
                clr = 1'b1;
                if (rise) state_nxt = HIGH;
            end
            HIGH: begin
                if (hi_long) begin
                    err_nxt   = 1'b1;
                    state_nxt = SYNC;
                end else if (bit_stb) begin
                    shift = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        valid_nxt = 1'b1;
                        state_nxt = FORWARD;
                    end else begin
                        state_nxt = LOW;
                    end
                end
            end
            // gap is tested before rise so an edge coinciding with the gap is dropped
            LOW: begin
                if (gap) begin
                    err_nxt   = 1'b1;
                    clr       = 1'b1;
                    state_nxt = READY;
                end else if (rise) begin
                    state_nxt = HIGH;
                end
            end
            FORWARD: begin
                dout_nxt = din_s;
                if (gap) begin
                    frame_nxt = 1'b1;
                    state_nxt = READY;
                end
            end
            default: state_nxt = SYNC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SYNC;
            bit_cnt <= '0;
            data    <= '0;
            valid   <= 1'b0;
            frame   <= 1'b0;
            err     <= 1'b0;
            dout    <= 1'b0;
        end else begin
            state <= state_nxt;
            valid <= valid_nxt;
            frame <= frame_nxt;
            err   <= err_nxt;
            dout  <= dout_nxt;
            if (clr) begin
                bit_cnt <= '0;
            end else if (shift) begin
                bit_cnt <= bit_cnt + 5'd1;
            end
            if (valid_nxt) begin
                data <= word_nxt;
            end
        end
    end

    // Shift register carries no reset: SYNC/READY clear it before any bit is accepted
    always_ff @(posedge clk) begin
        if (clr) begin
            shreg <= '0;
        end else if (shift) begin
            shreg <= word_nxt;
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Bench for ws2812_rx: drives WS2812 waveforms cycle by cycle and compares the decoded
// words, pulse counts, latencies and forwarded stream against a behavioural model.
module tb_ws2812_rx;

    localparam int N_THR  = 27;
    localparam int N_RST  = 2400;
    localparam int W0     = 19;
    localparam int W1     = 38;
    localparam int T_BIT  = 60;
    localparam int MAXC   = 90000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic        dout;
    logic [23:0] data;
    logic        valid;
    logic        frame;
    logic        err;

    ws2812_rx dut (
        .clk   (clk),
        .rst   (rst),
        .din   (din),
        .dout  (dout),
        .data  (data),
        .valid (valid),
        .frame (frame),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int   cyc = 0;
    logic din_h  [MAXC];
    logic dout_h [MAXC];
    int   valid_n = 0;
    int   frame_n = 0;
    int   err_n = 0;
    int   overlap_n = 0;
    int   valid_t = 0;
    int   frame_t = 0;
    int   last_fall_t = 0;

    // Sample index k = value of cyc after the k-th falling clock edge
    always @(negedge clk) begin
        if (cyc < MAXC - 1) begin
            din_h[cyc + 1]  <= din;
            dout_h[cyc + 1] <= dout;
        end
        cyc <= cyc + 1;
        if (valid === 1'b1) begin
            valid_n <= valid_n + 1;
            valid_t <= cyc + 1;
        end
        if (frame === 1'b1) begin
            frame_n <= frame_n + 1;
            frame_t <= cyc + 1;
        end
        if (err === 1'b1) err_n <= err_n + 1;
        if ((valid === 1'b1 && frame === 1'b1) || (valid === 1'b1 && err === 1'b1))
            overlap_n <= overlap_n + 1;
    end

    // Called and returns at posedge+1; holds din at v for n clocks
    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int w, input int period);
        hold(1'b1, w);
        last_fall_t = cyc + 1;
        hold(1'b0, period - w);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) begin
            send_bit(w[i] ? W1 : W0, T_BIT);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        din = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (data !== 24'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", data, 24'h0); end
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++;
        if (frame !== 1'b0) begin failures++; $display("FAIL reset_frame got=%b exp=0", frame); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++;
        if (dout !== 1'b0) begin failures++; $display("FAIL reset_dout got=%b exp=0", dout); end
        rst = 1'b0;
    endtask

    task automatic test_no_gap();
        int v0, f0;
        v0 = valid_n;
        f0 = frame_n;
        send_word(24'($urandom));
        checks++;
        if (valid_n !== v0) begin failures++; $display("FAIL nogap_valid got=%0d exp=%0d", valid_n - v0, 0); end
        checks++;
        if (frame_n !== f0) begin failures++; $display("FAIL nogap_frame got=%0d exp=%0d", frame_n - f0, 0); end
        hold(1'b0, N_RST + 50);
        send_word(24'h005500);
        hold(1'b0, 10);
        checks++;
        if (valid_n !== v0 + 1) begin failures++; $display("FAIL first_valid got=%0d exp=%0d", valid_n - v0, 1); end
        checks++;
        if (data !== 24'h005500) begin failures++; $display("FAIL first_data got=%h exp=%h", data, 24'h005500); end
        hold(1'b0, N_RST + 50);
        checks++;
        if (frame_n !== f0 + 1) begin failures++; $display("FAIL exact24_frame got=%0d exp=%0d", frame_n - f0, 1); end
    endtask

    task automatic test_threshold();
        int          v0;
        int          hw;
        logic [23:0] exp_w;
        for (int k = 0; k < 2; k++) begin
            hw = N_THR - 1 + k;
            exp_w = {23'b0, (hw >= N_THR)};
            hold(1'b0, N_RST + 50);
            v0 = valid_n;
            for (int i = 0; i < 23; i++) send_bit(W0, T_BIT);
            send_bit(hw, T_BIT);
            checks++;
            if (valid_n !== v0 + 1) begin failures++; $display("FAIL thr%0d_valid got=%0d exp=%0d", hw, valid_n - v0, 1); end
            checks++;
            if (data !== exp_w) begin failures++; $display("FAIL thr%0d_data got=%h exp=%h", hw, data, exp_w); end
        end
    endtask

    task automatic test_cascade();
        int v0, f0, t24, vt, mism, rises;
        hold(1'b0, N_RST + 50);
        v0 = valid_n;
        f0 = frame_n;
        send_word(24'h123456);
        t24 = last_fall_t;
        send_word(24'hABCDEF);
        checks++;
        if (valid_n !== v0 + 1) begin failures++; $display("FAIL casc_valid got=%0d exp=%0d", valid_n - v0, 1); end
        checks++;
        if (data !== 24'h123456) begin failures++; $display("FAIL casc_data got=%h exp=%h", data, 24'h123456); end
        vt = valid_t;
        checks++;
        if (vt !== t24 + 3) begin failures++; $display("FAIL casc_latency got=%0d exp=%0d", vt - t24, 3); end
        hold(1'b0, N_RST + 50);
        checks++;
        if (frame_n !== f0 + 1) begin failures++; $display("FAIL casc_frame got=%0d exp=%0d", frame_n - f0, 1); end
        checks++;
        if (frame_t < last_fall_t + N_RST || frame_t > last_fall_t + N_RST + 3) begin
            failures++;
            $display("FAIL casc_frame_time got=%0d exp=%0d..%0d", frame_t - last_fall_t, N_RST, N_RST + 3);
        end
        mism = 0;
        rises = 0;
        for (int t = vt; t <= frame_t && t < MAXC; t++) begin
            if (dout_h[t] !== din_h[t - 3]) mism++;
            if (dout_h[t] === 1'b1 && dout_h[t - 1] === 1'b0) rises++;
        end
        checks++;
        if (mism !== 0) begin failures++; $display("FAIL casc_dout_delay got=%0d exp=%0d", mism, 0); end
        checks++;
        if (rises !== 24) begin failures++; $display("FAIL casc_dout_bits got=%0d exp=%0d", rises, 24); end
    endtask

    task automatic test_partial();
        int          v0, e0;
        logic [23:0] d0;
        hold(1'b0, N_RST + 50);
        v0 = valid_n;
        e0 = err_n;
        d0 = data;
        for (int i = 0; i < 10; i++) send_bit(($urandom_range(0, 1) == 1) ? W1 : W0, T_BIT);
        hold(1'b0, N_RST + 50);
        checks++;
        if (err_n !== e0 + 1) begin failures++; $display("FAIL partial_err got=%0d exp=%0d", err_n - e0, 1); end
        checks++;
        if (valid_n !== v0) begin failures++; $display("FAIL partial_valid got=%0d exp=%0d", valid_n - v0, 0); end
        checks++;
        if (data !== d0) begin failures++; $display("FAIL partial_data got=%h exp=%h", data, d0); end
        send_word(24'hFF00FF);
        hold(1'b0, 5);
        checks++;
        if (valid_n !== v0 + 1) begin failures++; $display("FAIL after_partial_valid got=%0d exp=%0d", valid_n - v0, 1); end
        checks++;
        if (data !== 24'hFF00FF) begin failures++; $display("FAIL after_partial_data got=%h exp=%h", data, 24'hFF00FF); end
    endtask

    task automatic test_stuck();
        int v0, e0;
        hold(1'b0, N_RST + 50);
        v0 = valid_n;
        e0 = err_n;
        for (int i = 0; i < 5; i++) send_bit(W1, T_BIT);
        hold(1'b1, 300);
        checks++;
        if (err_n !== e0 + 1) begin failures++; $display("FAIL stuck_err got=%0d exp=%0d", err_n - e0, 1); end
        hold(1'b0, 60);
        send_word(24'h0000AA);
        hold(1'b0, 5);
        checks++;
        if (valid_n !== v0) begin failures++; $display("FAIL stuck_nogap_valid got=%0d exp=%0d", valid_n - v0, 0); end
        hold(1'b0, N_RST + 50);
        send_word(24'h0000AA);
        hold(1'b0, 5);
        checks++;
        if (valid_n !== v0 + 1) begin failures++; $display("FAIL stuck_valid got=%0d exp=%0d", valid_n - v0, 1); end
        checks++;
        if (data !== 24'h0000AA) begin failures++; $display("FAIL stuck_data got=%h exp=%h", data, 24'h0000AA); end
        checks++;
        if (err_n !== e0 + 1) begin failures++; $display("FAIL stuck_err_total got=%0d exp=%0d", err_n - e0, 1); end
    endtask

    task automatic test_rst_mid();
        int v0;
        hold(1'b0, N_RST + 50);
        v0 = valid_n;
        for (int i = 0; i < 11; i++) send_bit(W1, T_BIT);
        hold(1'b1, 10);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({data, valid, frame, err, dout} !== 28'h0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h/%b%b%b%b exp=0", data, valid, frame, err, dout);
        end
        rst = 1'b0;
        hold(1'b1, W1 - 11);
        hold(1'b0, T_BIT - W1);
        for (int i = 0; i < 12; i++) send_bit(W0, T_BIT);
        send_word(24'($urandom));
        hold(1'b0, 5);
        checks++;
        if (valid_n !== v0) begin failures++; $display("FAIL midrst_ignored got=%0d exp=%0d", valid_n - v0, 0); end
        hold(1'b0, N_RST + 50);
        send_word(24'h5A5A5A);
        hold(1'b0, 5);
        checks++;
        if (valid_n !== v0 + 1) begin failures++; $display("FAIL midrst_valid got=%0d exp=%0d", valid_n - v0, 1); end
        checks++;
        if (data !== 24'h5A5A5A) begin failures++; $display("FAIL midrst_data got=%h exp=%h", data, 24'h5A5A5A); end
    endtask

    // Reference: each pulse decodes by its high width alone; first 24 pulses form the word
    task automatic test_random();
        int          v0, f0, e0, nbits, w, t24;
        logic [23:0] exp_w;
        logic        b;
        for (int it = 0; it < 2; it++) begin
            hold(1'b0, N_RST + 50);
            v0 = valid_n;
            f0 = frame_n;
            e0 = err_n;
            exp_w = '0;
            t24 = 0;
            nbits = 24 + int'($urandom_range(0, 12));
            for (int k = 0; k < nbits; k++) begin
                b = ($urandom_range(0, 1) == 1);
                w = b ? int'($urandom_range(N_THR, 50)) : int'($urandom_range(6, N_THR - 1));
                if (k < 24) exp_w = {exp_w[22:0], (w >= N_THR)};
                send_bit(w, w + int'($urandom_range(10, 30)));
                if (k == 23) t24 = last_fall_t;
            end
            hold(1'b0, N_RST + 50);
            checks++;
            if (valid_n !== v0 + 1) begin failures++; $display("FAIL rnd%0d_valid got=%0d exp=%0d", it, valid_n - v0, 1); end
            checks++;
            if (data !== exp_w) begin failures++; $display("FAIL rnd%0d_data got=%h exp=%h", it, data, exp_w); end
            checks++;
            if (valid_t !== t24 + 3) begin failures++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, valid_t - t24, 3); end
            checks++;
            if (frame_n !== f0 + 1) begin failures++; $display("FAIL rnd%0d_frame got=%0d exp=%0d", it, frame_n - f0, 1); end
            checks++;
            if (err_n !== e0) begin failures++; $display("FAIL rnd%0d_err got=%0d exp=%0d", it, err_n - e0, 0); end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (overlap_n !== 0) begin failures++; $display("FAIL pulse_overlap got=%0d exp=%0d", overlap_n, 0); end
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_no_gap();
        test_threshold();
        test_cascade();
        test_partial();
        test_stuck();
        test_rst_mid();
        test_random();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
